// File: rtl/chain_tap.sv
// Receive-side tap point of a daisy-chained packet ring: steers each AXI Stream packet to the
// local consumer, down the chain, or both, based on the destination ID in its head flit.
`timescale 1ns/1ps

module chain_tap_buf #(
   parameter int unsigned W = 65
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   output logic         rdy_o,
   output logic [W-1:0] dout_o,
   output logic         valid_o,
   input  logic         ready_i
);
   logic [W-1:0] mem_q [2];
   logic         wr_q;
   logic         rd_q;
   logic [1:0]   cnt_q;
   logic         pop;

   // Ready comes from registered occupancy only, so push never meets a full buffer.
   assign rdy_o   = (cnt_q != 2'd2);
   assign valid_o = (cnt_q != 2'd0);
   assign dout_o  = mem_q[rd_q];
   assign pop     = valid_o && ready_i;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (push_i) wr_q <= ~wr_q;
         if (pop)    rd_q <= ~rd_q;
         cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end
endmodule

module chain_tap #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned MY_ID      = 0,
   parameter int unsigned BCAST_EN   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_TDATA,
   input  logic                  in_TVALID,
   output logic                  in_TREADY,
   input  logic                  in_TLAST,
   output logic [DATA_WIDTH-1:0] loc_TDATA,
   output logic                  loc_TVALID,
   input  logic                  loc_TREADY,
   output logic                  loc_TLAST,
   output logic [DATA_WIDTH-1:0] nxt_TDATA,
   output logic                  nxt_TVALID,
   input  logic                  nxt_TREADY,
   output logic                  nxt_TLAST,
   output logic                  mid_pkt
);
   typedef enum logic [1:0] {RT_UNDEC, RT_LOC, RT_NXT, RT_BOTH} route_e;

   route_e              state_q, state_d;
   route_e              head_route, route;
   logic [ID_WIDTH-1:0] id;
   logic                accept;
   logic                loc_push, nxt_push;
   logic                loc_rdy, nxt_rdy;

   assign id = in_TDATA[DATA_WIDTH-1 -: ID_WIDTH];

   // MY_ID is tested first so an all-ones local ID is never broadcast.
   always_comb begin
      head_route = RT_NXT;
      if (id == ID_WIDTH'(MY_ID))               head_route = RT_LOC;
      else if ((BCAST_EN != 0) && (id == '1))   head_route = RT_BOTH;
   end

   always_comb begin
      route     = (state_q == RT_UNDEC) ? head_route : state_q;
      in_TREADY = 1'b0;
      case (route)
         RT_LOC:  in_TREADY = loc_rdy;
         RT_NXT:  in_TREADY = nxt_rdy;
         RT_BOTH: in_TREADY = loc_rdy && nxt_rdy;
         default: in_TREADY = 1'b0;
      endcase
      accept   = in_TVALID && in_TREADY;
      loc_push = accept && ((route == RT_LOC) || (route == RT_BOTH));
      nxt_push = accept && ((route == RT_NXT) || (route == RT_BOTH));
      state_d  = state_q;
      if (accept) state_d = in_TLAST ? RT_UNDEC : route;
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= RT_UNDEC;
      else      state_q <= state_d;
   end

   assign mid_pkt = (state_q != RT_UNDEC);

   chain_tap_buf #(.W(DATA_WIDTH + 1)) u_loc_buf (
      .clk     (clk),
      .rst     (rst),
      .push_i  (loc_push),
      .din_i   ({in_TLAST, in_TDATA}),
      .rdy_o   (loc_rdy),
      .dout_o  ({loc_TLAST, loc_TDATA}),
      .valid_o (loc_TVALID),
      .ready_i (loc_TREADY)
   );

   chain_tap_buf #(.W(DATA_WIDTH + 1)) u_nxt_buf (
      .clk     (clk),
      .rst     (rst),
      .push_i  (nxt_push),
      .din_i   ({in_TLAST, in_TDATA}),
      .rdy_o   (nxt_rdy),
      .dout_o  ({nxt_TLAST, nxt_TDATA}),
      .valid_o (nxt_TVALID),
      .ready_i (nxt_TREADY)
   );
endmodule
